lsu_bus_master: RTL and testbench
=================================

// Module: lsu_bus_master
// PURPOSE
//  Parametrised load/store unit between the multi-cycle datapath and the data bus.
//  Adds a req/ready handshake with wait states, byte enables for stores, misalign and
//  illegal-func3 detection, a bus timeout, and an optional 64-bit data path.
//  The control unit launches one access per start pulse and waits for done.
//  Loads are lane-extracted and sign/zero-extended here before register-file writeback.
// PARAMETERS
//  DATA_W   32  bus/register width; legal values 32 or 64; LANES = DATA_W/8
//  ADDR_W   32  byte address width
//  TIMEOUT  15  cycles ACCESS waits for busReady before error; 0 = wait forever
// PORTS
//  clk         in   1         clock; all state changes on posedge
//  reset       in   1         synchronous, active-high reset
//  start       in   1         launch access; sampled only in IDLE
//  isStore     in   1         1 = store, 0 = load
//  func3       in   3         RV funct3 (LB/LH/LW/LBU/LHU; LD/LWU/SD only when DATA_W=64)
//  addr        in   ADDR_W    byte address (ALU result)
//  wdata       in   DATA_W    store data (rs2), right-aligned
//  busy        out  1         high from cycle after accepted start until done cycle inclusive
//  done        out  1         one-cycle completion pulse
//  err         out  1         valid with done: misaligned, illegal func3 or timeout
//  rdata       out  DATA_W    processed load data; held until next accepted start
//  busReq      out  1         bus request, held until busReady
//  busWe       out  1         1 = write
//  busAddr     out  ADDR_W    addr with low log2(LANES) bits cleared
//  busBe       out  LANES     byte enables (stores); all zero for loads
//  busWData    out  DATA_W    store data shifted into addressed lanes
//  busReady    in   1         slave accepts/completes access this cycle
//  busRData    in   DATA_W    read data, valid when busReady and !busWe
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, busReq, busWe = 0; busAddr, busBe, busWData,
//   rdata, timeout counter = 0. Reset mid-access aborts: no done, busReq low next cycle.
//  States: IDLE, ACCESS, DONE.
//  IDLE: start=1 -> latch isStore/func3/addr/wdata. Size: b=1, h=2, w=4, d=8 bytes.
//   Illegal func3 (load 011/110 at DATA_W=32, 111 always; store func3>=011 at 32,
//   >=100 at 64) or addr%size!=0 -> DONE with err=1; busReq never asserted.
//   Else -> ACCESS; compute busAddr, busBe = ((1<<size)-1) << off,
//   busWData = wdata << (8*off), off = addr % LANES.
//  ACCESS: busReq=1, busWe=isStore, busAddr/busBe/busWData stable until handshake.
//   busReady=1 -> capture busRData (loads) -> DONE, err=0; busReq low next cycle.
//   Counter increments each ACCESS cycle without busReady; TIMEOUT!=0 and count reaches
//   TIMEOUT -> DONE, err=1, busReq drops. busReady in the same cycle as timeout wins.
//  DONE: done=1 one cycle, busy=1, err valid -> IDLE. rdata updated on entry to DONE
//   for successful loads; stores and errored accesses leave rdata unchanged.
//  Load extract: lane = busRData >> (8*off); LB/LH/LW sign-extend, LBU/LHU/LWU
//   zero-extend to DATA_W; LW at 32 and LD at 64 pass through.
//  start while not IDLE ignored (not queued). Min latency: start at cycle N,
//   busReq at N+1, busReady at N+1 -> done at N+2. Error path: done at N+1.
//  All outputs registered; no combinational path from bus inputs to outputs.
// TESTING
//  LB addr=0x1003, busRData=0x80AABBCC, ready first cycle -> busAddr=0x1000, busBe=0,
//   rdata=0xFFFFFF80, done 2 cycles after start, err=0.
//  SH addr=0x2002 wdata=0x1234ABCD, ready after 3 wait cycles -> busWe=1, busBe=4'b1100,
//   busWData[31:16]=0xABCD, busReq high 4 cycles, done the cycle after ready.
//  LW addr=0x0006 -> done+err the cycle after start, busReq never 1, rdata unchanged.
//  TIMEOUT=4, busReady held 0 -> busReq high exactly 4 cycles, then done=1 err=1.
//  Reset asserted in 2nd ACCESS cycle -> next cycle busReq=0, busy=0, no done pulse;
//   start pulsed during ACCESS is ignored.
//  DATA_W=64: LWU addr=0x104 busRData=0x80000001_00000000 -> busAddr=0x100, rdata=0x80000001;
//   SD addr=0x108 -> busBe=8'hFF.

Source files
------------

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: load/store unit between the multi-cycle datapath and the data bus.
// Each accepted start launches one access. Stores get byte enables and lane-shifted
// data. Loads are lane-extracted and sign/zero-extended before writeback.
// Misaligned addresses, illegal func3 and bus timeouts all complete with err set.
// Every output comes straight from a flop, so no bus input reaches an output
// combinationally.
module lsu_bus_master #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                isStore,
    input  logic [2:0]          func3,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                busReq,
    output logic                busWe,
    output logic [ADDR_W-1:0]   busAddr,
    output logic [DATA_W/8-1:0] busBe,
    output logic [DATA_W-1:0]   busWData,
    input  logic                busReady,
    input  logic [DATA_W-1:0]   busRData
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic              is_store_q, is_store_d;
    logic [2:0]        func3_q, func3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [LANES-1:0]  bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    logic              req_illegal;
    logic              req_misaligned;
    logic              req_bad;
    logic [OFF_W-1:0]  req_off;
    logic [LANES-1:0]  req_be;
    logic              timeout_hit;
    logic [DATA_W-1:0] load_lane;
    logic [DATA_W-1:0] load_ext;

    // Decode an incoming request: legality, alignment, lane offset and byte-enable mask
    always_comb begin
        req_illegal = 1'b0;
        if (isStore) begin
            req_illegal = (DATA_W == 64) ? func3[2] : (func3 >= 3'd3);
        end else begin
            case (func3)
                3'b011, 3'b110: req_illegal = (DATA_W != 64);
                3'b111:         req_illegal = 1'b1;
                default:        req_illegal = 1'b0;
            endcase
        end

        case (func3[1:0])
            2'b01:   req_misaligned = addr[0];
            2'b10:   req_misaligned = |addr[1:0];
            2'b11:   req_misaligned = |addr[2:0];
            default: req_misaligned = 1'b0;
        endcase

        req_bad = req_illegal | req_misaligned;
        req_off = addr[OFF_W-1:0];

        case (func3[1:0])
            2'b00:   req_be = LANES'(8'h01);
            2'b01:   req_be = LANES'(8'h03);
            2'b10:   req_be = LANES'(8'h0F);
            default: req_be = LANES'(8'hFF);
        endcase
        req_be = req_be << req_off;
    end

    // The timeout fires when the wait counter has already seen TIMEOUT-1 idle bus cycles
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // Pull the addressed lane down to bit 0 and extend it to full width
    always_comb begin
        load_lane = busRData >> {off_q, 3'b000};
        case (func3_q)
            3'b000:  load_ext = DATA_W'($signed(load_lane[7:0]));
            3'b001:  load_ext = DATA_W'($signed(load_lane[15:0]));
            3'b010:  load_ext = DATA_W'($signed(load_lane[31:0]));
            3'b100:  load_ext = DATA_W'(load_lane[7:0]);
            3'b101:  load_ext = DATA_W'(load_lane[15:0]);
            3'b110:  load_ext = DATA_W'(load_lane[31:0]);
            default: load_ext = load_lane;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: rejected requests bypass ACCESS; busReady beats a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = req_bad ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (busReady || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: compute the next value of every registered output and of the latched request
    always_comb begin
        is_store_d  = is_store_q;
        func3_d     = func3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_store_d = isStore;
                    func3_d    = func3;
                    off_d      = req_off;
                    cnt_d      = '0;
                    if (req_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = isStore;
                        bus_addr_d  = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_be_d    = isStore ? req_be : '0;
                        bus_wdata_d = wdata << {req_off, 3'b000};
                    end
                end
            end
            ST_ACCESS: begin
                if (busReady) begin
                    done_d = 1'b1;
                    if (!is_store_q) begin
                        rdata_d = load_ext;
                    end
                end else if (timeout_hit) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    bus_req_d = 1'b1;
                    bus_we_d  = is_store_q;
                    if (TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_q  <= 1'b0;
            func3_q     <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            is_store_q  <= is_store_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign busReq   = bus_req_q;
    assign busWe    = bus_we_q;
    assign busAddr  = bus_addr_q;
    assign busBe    = bus_be_q;
    assign busWData = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: drives a 32-bit and a 64-bit instance (both TIMEOUT=4) through a
// table of directed accesses, hand-written reset/ignored-start sequences and randomized
// accesses, comparing against a byte-arithmetic reference model.
module tb_lsu_bus_master;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start32, start64;
    logic        is_store;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        bus_ready;
    logic [63:0] bus_rdata;

    logic        busy32, done32, err32, bus_req32, bus_we32;
    logic [31:0] rdata32, bus_addr32, bus_wdata32;
    logic [3:0]  bus_be32;
    logic        busy64, done64, err64, bus_req64, bus_we64;
    logic [63:0] rdata64, bus_wdata64;
    logic [31:0] bus_addr64;
    logic [7:0]  bus_be64;

    int checks = 0;
    int passes = 0;
    logic [63:0] model_rd [2];

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } outs_t;

    typedef struct {
        bit          w64;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        int          wait_cyc;
        logic        exp_err;
        int          exp_req;
        logic [31:0] exp_addr;
        logic [63:0] exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    lsu_bus_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .isStore(is_store), .func3(func3),
        .addr(addr), .wdata(wdata[31:0]), .busy(busy32), .done(done32), .err(err32),
        .rdata(rdata32), .busReq(bus_req32), .busWe(bus_we32), .busAddr(bus_addr32),
        .busBe(bus_be32), .busWData(bus_wdata32), .busReady(bus_ready),
        .busRData(bus_rdata[31:0])
    );

    lsu_bus_master #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TMO)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .isStore(is_store), .func3(func3),
        .addr(addr), .wdata(wdata), .busy(busy64), .done(done64), .err(err64),
        .rdata(rdata64), .busReq(bus_req64), .busWe(bus_we64), .busAddr(bus_addr64),
        .busBe(bus_be64), .busWData(bus_wdata64), .busReady(bus_ready),
        .busRData(bus_rdata)
    );

    function automatic outs_t getOuts(input bit w64);
        outs_t o;
        if (w64) begin
            o = {busy64, done64, err64, bus_req64, bus_we64, bus_addr64, bus_be64,
                 bus_wdata64, rdata64};
        end else begin
            o = {busy32, done32, err32, bus_req32, bus_we32, bus_addr32, {4'b0, bus_be32},
                 {32'b0, bus_wdata32}, {32'b0, rdata32}};
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Reference model: works in bytes and lanes, straight from the access rules
    task automatic modelAccess(input bit w64, input bit st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [63:0] wd,
                               input logic [63:0] rd, input int wait_cyc,
                               input logic [63:0] prev_rd,
                               output logic e_err, output int e_req,
                               output logic [31:0] e_addr, output logic [63:0] e_be,
                               output logic [63:0] e_wdata, output logic [63:0] e_rdata);
        int lanes;
        int bytes;
        int off;
        bit legal;
        bit aligned;
        logic [63:0] wmask;
        logic [63:0] vmask;
        logic [63:0] val;
        lanes = w64 ? 8 : 4;
        bytes = 1 << f3[1:0];
        if (st) legal = (f3 < (w64 ? 3'd4 : 3'd3));
        else    legal = (f3 != 3'd7) && (w64 || (f3 != 3'd3 && f3 != 3'd6));
        aligned = (a % bytes) == 0;
        off     = a % lanes;
        wmask   = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e_addr  = a - off;
        e_be    = st ? (((64'd1 << bytes) - 64'd1) << off) : 64'd0;
        e_wdata = (wd << (8 * off)) & wmask;
        val     = (rd & wmask) >> (8 * off);
        if (bytes < 8) begin
            vmask = (64'd1 << (8 * bytes)) - 64'd1;
            val   = val & vmask;
            if (!f3[2] && val[8*bytes-1]) val = val | ~vmask;
        end
        val = val & wmask;
        if (!legal || !aligned) begin
            e_err = 1'b1; e_req = 0; e_rdata = prev_rd;
        end else if (wait_cyc >= TMO) begin
            e_err = 1'b1; e_req = TMO; e_rdata = prev_rd;
        end else begin
            e_err = 1'b0; e_req = wait_cyc + 1; e_rdata = st ? prev_rd : val;
        end
    endtask

    task automatic addVec(input bit w64, input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] wd, input logic [63:0] rd, input int wait_cyc,
                          input logic e_err, input int e_req, input logic [31:0] e_addr,
                          input logic [63:0] e_be, input logic [63:0] e_wdata,
                          input logic [63:0] e_rdata);
        vec_t v;
        v.w64 = w64; v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd;
        v.wait_cyc = wait_cyc; v.exp_err = e_err; v.exp_req = e_req; v.exp_addr = e_addr;
        v.exp_be = e_be; v.exp_wdata = e_wdata; v.exp_rdata = e_rdata;
        vecs.push_back(v);
    endtask

    // Runs one access from an IDLE negedge; exp_req is the number of busReq cycles expected
    task automatic applyStimulus(input bit w64, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [63:0] wd,
                                 input logic [63:0] rd, input int wait_cyc,
                                 input logic e_err, input int e_req, input logic [31:0] e_addr,
                                 input logic [63:0] e_be, input logic [63:0] e_wdata,
                                 input logic [63:0] e_rdata, input string tag);
        outs_t o;
        is_store  = st;
        func3     = f3;
        addr      = a;
        wdata     = wd;
        bus_ready = 1'b0;
        if (w64) start64 = 1'b1;
        else     start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        start64 = 1'b0;
        for (int k = 0; k < e_req; k++) begin
            o = getOuts(w64);
            checkOutput({tag, " busReq"}, 64'(o.req), 64'd1);
            checkOutput({tag, " done-early"}, 64'(o.done), 64'd0);
            if (k == 0) begin
                checkOutput({tag, " busy"}, 64'(o.busy), 64'd1);
                checkOutput({tag, " busWe"}, 64'(o.we), 64'(st));
                checkOutput({tag, " busAddr"}, 64'(o.addr), 64'(e_addr));
                checkOutput({tag, " busBe"}, 64'(o.be), e_be);
                checkOutput({tag, " busWData"}, o.wdata, e_wdata);
            end
            bus_ready = (k == wait_cyc);
            bus_rdata = bus_ready ? rd : {$urandom, $urandom};
            @(negedge clk);
        end
        bus_ready = 1'b0;
        o = getOuts(w64);
        checkOutput({tag, " done"}, 64'(o.done), 64'd1);
        checkOutput({tag, " err"}, 64'(o.err), 64'(e_err));
        checkOutput({tag, " busReq-off"}, 64'(o.req), 64'd0);
        checkOutput({tag, " busy-done"}, 64'(o.busy), 64'd1);
        checkOutput({tag, " rdata"}, o.rdata, e_rdata);
        @(negedge clk);
        o = getOuts(w64);
        checkOutput({tag, " done-pulse"}, 64'(o.done), 64'd0);
        checkOutput({tag, " busy-idle"}, 64'(o.busy), 64'd0);
        model_rd[w64] = e_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          r_w64;
        bit          r_st;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        logic [63:0] r_wd;
        logic [63:0] r_rd;
        int          r_wait;
        logic        e_err;
        int          e_req;
        logic [31:0] e_addr;
        logic [63:0] e_be;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
        outs_t       o;

        // Directed table: {w64, st, f3, addr, wdata, busRData, wait, err, reqCycles, busAddr, busBe, busWData, rdata}
        addVec(0, 0, 3'b000, 32'h1003, 64'h0, 64'h80AABBCC, 0, 0, 1, 32'h1000, 64'h0, 64'h0, 64'hFFFFFF80);
        addVec(0, 1, 3'b001, 32'h2002, 64'h1234ABCD, 64'h0, 3, 0, 4, 32'h2000, 64'hC, 64'hABCD0000, 64'hFFFFFF80);
        addVec(0, 0, 3'b010, 32'h0006, 64'h0, 64'h0, 0, 1, 0, 32'h0, 64'h0, 64'h0, 64'hFFFFFF80);
        addVec(0, 0, 3'b010, 32'h0040, 64'h0, 64'h0, 9, 1, 4, 32'h40, 64'h0, 64'h0, 64'hFFFFFF80);
        addVec(0, 0, 3'b101, 32'h0012, 64'h0, 64'hBEEF1234, 1, 0, 2, 32'h10, 64'h0, 64'h0, 64'h0000BEEF);
        addVec(0, 0, 3'b001, 32'h0022, 64'h0, 64'h8001FFFF, 0, 0, 1, 32'h20, 64'h0, 64'h0, 64'hFFFF8001);
        addVec(0, 0, 3'b011, 32'h0000, 64'h0, 64'h0, 0, 1, 0, 32'h0, 64'h0, 64'h0, 64'hFFFF8001);
        addVec(0, 1, 3'b000, 32'h0007, 64'hA5, 64'h0, 0, 0, 1, 32'h4, 64'h8, 64'hA5000000, 64'hFFFF8001);
        addVec(0, 0, 3'b100, 32'h0031, 64'h0, 64'hF200, 3, 0, 4, 32'h30, 64'h0, 64'h0, 64'hF2);
        addVec(1, 0, 3'b110, 32'h0104, 64'h0, 64'h80000001_00000000, 0, 0, 1, 32'h100, 64'h0, 64'h0, 64'h80000001);
        addVec(1, 1, 3'b011, 32'h0108, 64'h11223344_55667788, 64'h0, 2, 0, 3, 32'h108, 64'hFF, 64'h11223344_55667788, 64'h80000001);
        addVec(1, 0, 3'b010, 32'h010C, 64'h0, 64'h89ABCDEF_00000000, 1, 0, 2, 32'h108, 64'h0, 64'h0, 64'hFFFFFFFF_89ABCDEF);
        addVec(1, 1, 3'b100, 32'h0200, 64'h55, 64'h0, 0, 1, 0, 32'h0, 64'h0, 64'h0, 64'hFFFFFFFF_89ABCDEF);
        addVec(1, 0, 3'b011, 32'h0104, 64'h0, 64'h0, 0, 1, 0, 32'h0, 64'h0, 64'h0, 64'hFFFFFFFF_89ABCDEF);

        reset     = 1'b1;
        start32   = 1'b0;
        start64   = 1'b0;
        is_store  = 1'b0;
        func3     = 3'b000;
        addr      = '0;
        wdata     = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state of both instances
        for (int w = 0; w < 2; w++) begin
            o = getOuts(w == 1);
            checkOutput($sformatf("reset%0d busy", w), 64'(o.busy), 64'd0);
            checkOutput($sformatf("reset%0d done", w), 64'(o.done), 64'd0);
            checkOutput($sformatf("reset%0d err", w), 64'(o.err), 64'd0);
            checkOutput($sformatf("reset%0d busReq", w), 64'(o.req), 64'd0);
            checkOutput($sformatf("reset%0d busWe", w), 64'(o.we), 64'd0);
            checkOutput($sformatf("reset%0d busAddr", w), 64'(o.addr), 64'd0);
            checkOutput($sformatf("reset%0d busBe", w), 64'(o.be), 64'd0);
            checkOutput($sformatf("reset%0d busWData", w), o.wdata, 64'd0);
            checkOutput($sformatf("reset%0d rdata", w), o.rdata, 64'd0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].w64, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                          vecs[i].rd, vecs[i].wait_cyc, vecs[i].exp_err, vecs[i].exp_req,
                          vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_wdata,
                          vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // Start during ACCESS is ignored; reset in the 2nd ACCESS cycle aborts with no done
        is_store  = 1'b0;
        func3     = 3'b010;
        addr      = 32'h50;
        bus_ready = 1'b0;
        start32   = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        checkOutput("abort busReq1", 64'(bus_req32), 64'd1);
        addr    = 32'h80;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        checkOutput("ignored-start busAddr", 64'(bus_addr32), 64'h50);
        checkOutput("abort busReq2", 64'(bus_req32), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busReq", 64'(bus_req32), 64'd0);
        checkOutput("abort busy", 64'(busy32), 64'd0);
        checkOutput("abort done", 64'(done32), 64'd0);
        checkOutput("abort rdata", 64'(rdata32), 64'd0);
        @(negedge clk);
        checkOutput("abort no-late-done", 64'(done32), 64'd0);
        checkOutput("abort no-relaunch", 64'(bus_req32), 64'd0);
        model_rd[0] = '0;
        model_rd[1] = '0;

        // Randomized accesses against the reference model
        for (int i = 0; i < 80; i++) begin
            r_w64  = 1'($urandom_range(0, 1));
            r_st   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) begin
                r_addr = r_addr & ~((32'd1 << r_f3[1:0]) - 32'd1);
            end
            r_wd   = {$urandom, $urandom};
            r_rd   = {$urandom, $urandom};
            r_wait = $urandom_range(0, 5);
            modelAccess(r_w64, r_st, r_f3, r_addr, r_wd, r_rd, r_wait, model_rd[r_w64],
                        e_err, e_req, e_addr, e_be, e_wdata, e_rdata);
            applyStimulus(r_w64, r_st, r_f3, r_addr, r_wd, r_rd, r_wait, e_err, e_req,
                          e_addr, e_be, e_wdata, e_rdata, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
